// File: rtl/ahfp_accum_stream.sv
// ahfp_accum_stream: streaming IEEE-754 single-precision accumulator that drives an external pipelined FP adder.
// Latency: out_valid rises LATENCY*LATENCY+2 cycles after the in_last accept (51 for LATENCY=7).
// Backpressure: in_ready is high only while accumulating; the result is held in DONE until out_ready.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   in_valid/in_ready    input word handshake; in_data operand, in_last marks the final word of a frame
//   out_valid/out_ready  result handshake; out_data is the frame sum
//   add_a/add_b          operands to the external adder (combinational, zero when not issuing)
//   add_res              adder result, LATENCY cycles after the operands were presented
module ahfp_accum_stream #(
  parameter int LATENCY = 7,
  parameter int SLOT_W  = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  input  logic [31:0] add_res
);

  typedef enum logic [1:0] {ACC, WAIT, DRAIN, DONE} state_t;

  localparam logic [SLOT_W-1:0] SLOT_MAX = SLOT_W'(LATENCY - 1);
  localparam logic [SLOT_W-1:0] IDX_ONE  = SLOT_W'(1);
  localparam logic [SLOT_W:0]   DCNT_LAT = (SLOT_W + 1)'(LATENCY);
  localparam logic [SLOT_W:0]   DCNT_ONE = (SLOT_W + 1)'(1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [SLOT_W-1:0]  r_slot;
  logic [LATENCY-1:0] r_fl;                  // one bit per adder stage: result in flight
  logic [31:0]        r_partial [LATENCY];   // one partial sum per adder slot
  logic [SLOT_W-1:0]  r_idx;                 // next partial to fold in during DRAIN
  logic [SLOT_W:0]    r_dcnt;                // cycles since the last DRAIN issue
  logic [31:0]        r_out_data;

  logic               w_accept;
  logic [31:0]        w_cur;
  logic               w_first;
  logic               w_capture;
  logic               w_final;
  logic [SLOT_W-1:0]  w_idx_nxt;
  logic               w_acc_phase;

  assign in_ready    = (r_state == ACC);
  assign out_valid   = (r_state == DONE);
  assign out_data    = r_out_data;
  assign w_accept    = in_valid & in_ready;
  assign w_acc_phase = (r_state == ACC) || (r_state == WAIT);

  // The slot period equals the adder latency, so a result always lands back on
  // the slot that issued it; when it lands it supersedes the stale stored value.
  assign w_cur = r_fl[LATENCY-1] ? add_res : r_partial[r_slot];

  // DRAIN: first cycle folds partial[0] with partial[1]; afterwards each add is
  // captured exactly LATENCY cycles after issue and the next one chains off add_res.
  assign w_first   = (r_state == DRAIN) && (r_dcnt == '0);
  assign w_capture = (r_state == DRAIN) && (r_dcnt == DCNT_LAT);
  assign w_final   = w_capture && (r_idx == SLOT_MAX);
  assign w_idx_nxt = r_idx + IDX_ONE;

  always_comb begin
    w_state_nxt = r_state;
    add_a       = 32'h0;
    add_b       = 32'h0;
    case (r_state)
      ACC: begin
        if (w_accept) begin
          add_a = in_data;
          add_b = w_cur;
          if (in_last) w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        // Only the oldest stage may still be set; it is written back this cycle,
        // so every partial is settled by the first DRAIN cycle.
        if (r_fl[LATENCY-2:0] == '0) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (w_first) begin
          add_a = r_partial[0];
          add_b = r_partial[r_idx];
        end else if (w_capture) begin
          if (w_final) begin
            w_state_nxt = DONE;
          end else begin
            add_a = add_res;
            add_b = r_partial[w_idx_nxt];
          end
        end
      end
      DONE: begin
        if (out_ready) w_state_nxt = ACC;
      end
      default: w_state_nxt = ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ACC;
      r_slot     <= '0;
      r_fl       <= '0;
      r_idx      <= '0;
      r_dcnt     <= '0;
      r_out_data <= 32'h0;
      for (int i = 0; i < LATENCY; i++) r_partial[i] <= 32'h0;
    end else begin
      r_state <= w_state_nxt;
      r_fl    <= {r_fl[LATENCY-2:0], w_accept};

      if (w_acc_phase) begin
        r_slot <= (r_slot == SLOT_MAX) ? '0 : r_slot + IDX_ONE;
        // An accepted word keeps the slot value in flight; only a returning
        // result with nothing new to add is parked in the partial array.
        if (!w_accept && r_fl[LATENCY-1]) r_partial[r_slot] <= add_res;
      end

      if (r_state == WAIT) begin
        r_dcnt <= '0;
        r_idx  <= IDX_ONE;
      end else if (r_state == DRAIN) begin
        if (w_capture) begin
          r_dcnt <= DCNT_ONE;
          r_idx  <= w_idx_nxt;
        end else begin
          r_dcnt <= r_dcnt + DCNT_ONE;
        end
        if (w_final) r_out_data <= add_res;
      end

      if ((r_state == DONE) && out_ready) begin
        r_slot <= '0;
        for (int i = 0; i < LATENCY; i++) r_partial[i] <= 32'h0;
      end
    end
  end

endmodule

// File: tb/tb_ahfp_accum_stream.sv
// tb_ahfp_accum_stream: bench for the streaming FP accumulator with a behavioural pipelined adder.
// Latency: the adder model returns add_a+add_b exactly L cycles after presentation.
// Backpressure: out_ready is held low for a stretch in one frame to check the DONE hold.
module tb_ahfp_accum_stream;

  localparam int L = 7;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic [31:0] add_res;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  ahfp_accum_stream #(.LATENCY(L), .SLOT_W(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_res  (add_res)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Single <-> double conversion; every value in this bench is exactly representable.
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'h0) return 0.0;
    d = {f[31], ({3'b000, f[30:23]} + 11'd896), f[22:0], 29'b0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:0] == 63'h0) return 32'h0;
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  logic [31:0] pipe [L];
  always @(posedge clk) begin
    pipe[0] <= r2f(f2r(add_a) + f2r(add_b));
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
  end
  assign add_res = pipe[L-1];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, " in_ready"}, 32'(in_ready), 32'd1);
    chk({nm, " out_valid"}, 32'(out_valid), 32'd0);
    chk({nm, " out_data"}, out_data, 32'h0);
    chk({nm, " add_a"}, add_a, 32'h0);
    chk({nm, " add_b"}, add_b, 32'h0);
  endtask

  // Called at posedge+1 of the cycle after the in_last accept.
  task automatic collect(input logic [31:0] exp, input int acc_cyc, input int stall, input string nm);
    int b = 0;
    bit ir_bad = 0;
    bit st_bad = 0;
    #1;
    while (!out_valid && b < 200) begin
      if (in_ready) ir_bad = 1;
      tick(); #1; b++;
    end
    chk({nm, " out_valid rise"}, 32'(out_valid), 32'd1);
    chk({nm, " latency"}, 32'(cyc - acc_cyc), 32'd51);
    chk({nm, " in_ready low"}, 32'(ir_bad | in_ready), 32'd0);
    chk({nm, " out_data"}, out_data, exp);
    repeat (stall) begin
      if (!out_valid || out_data !== exp) st_bad = 1;
      tick(); #1;
    end
    if (stall > 0) chk({nm, " hold stable"}, 32'(st_bad | !out_valid), 32'd0);
    out_ready = 1'b1;
    #1;
    tick(); #1;
    chk({nm, " out_valid after hs"}, 32'(out_valid), 32'd0);
    chk({nm, " in_ready after hs"}, 32'(in_ready), 32'd1);
  endtask

  task automatic run_frame(input int n, input logic [0:3][31:0] w, input logic [31:0] exp,
                           input int stall, input string nm);
    int acc = 0;
    int b;
    out_ready = (stall == 0);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1; in_data = w[i]; in_last = (i == n - 1);
      #1;
      b = 0;
      while (!in_ready && b < 100) begin tick(); #1; b++; end
      chk({nm, " word accepted"}, 32'(in_ready), 32'd1);
      acc = cyc;
      tick();
    end
    in_valid = 1'b0; in_last = 1'b0;
    collect(exp, acc, stall, nm);
  endtask

  typedef struct {
    int               n;
    logic [0:3][31:0] w;
    logic [31:0]      exp;
    int               stall;
  } vec_t;

  vec_t vecs [4];
  int   gaps [10] = '{0, 3, 0, 9, 1, 0, 12, 0, 2, 0};
  int   cnt  [L];

  initial begin
    int k;
    int acc;
    int b;
    bit ov_bad;

    vecs[0] = '{n: 3, w: {32'h3F800000, 32'h40000000, 32'h40400000, 32'h0}, exp: 32'h40C00000, stall: 0};
    vecs[1] = '{n: 1, w: {32'h40A00000, 32'h0, 32'h0, 32'h0},               exp: 32'h40A00000, stall: 0};
    vecs[2] = '{n: 3, w: {32'h3FC00000, 32'hBF000000, 32'h40000000, 32'h0}, exp: 32'h40400000, stall: 20};
    vecs[3] = '{n: 1, w: {32'h40000000, 32'h0, 32'h0, 32'h0},               exp: 32'h40000000, stall: 0};

    reset = 1'b1; in_valid = 1'b0; in_data = 32'h0; in_last = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    #1;
    chk_reset("reset");

    // Ten 1.0 words with gaps; current cycle is slot 0. The partial for a slot
    // equals the number of words already accepted on that slot.
    for (int i = 0; i < L; i++) cnt[i] = 0;
    k = 0; acc = 0;
    for (int w = 0; w < 10; w++) begin
      for (int g = 0; g < gaps[w]; g++) begin
        in_valid = 1'b0; #1;
        chk("ten idle add_a", add_a, 32'h0);
        chk("ten idle add_b", add_b, 32'h0);
        tick(); k++;
      end
      in_valid = 1'b1; in_data = 32'h3F800000; in_last = (w == 9);
      #1;
      chk("ten in_ready", 32'(in_ready), 32'd1);
      chk("ten add_a", add_a, 32'h3F800000);
      chk("ten add_b", add_b, r2f(real'(cnt[k % L])));
      cnt[k % L]++;
      acc = cyc;
      tick(); k++;
    end
    in_valid = 1'b0; in_last = 1'b0;
    collect(32'h41200000, acc, 0, "ten");

    for (int v = 0; v < 4; v++)
      run_frame(vecs[v].n, vecs[v].w, vecs[v].exp, vecs[v].stall, $sformatf("vec%0d", v));

    // Reset mid-frame in ACC.
    in_valid = 1'b1; in_data = 32'h3F800000; in_last = 1'b0;
    tick();
    in_data = 32'h40000000;
    tick();
    in_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk_reset("acc reset");

    // Reset during DRAIN of a one-word frame.
    in_valid = 1'b1; in_data = 32'h40A00000; in_last = 1'b1;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    repeat (20) tick();
    #1;
    chk("drain busy", 32'(in_ready), 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk_reset("drain reset");
    ov_bad = 0;
    for (b = 0; b < 60; b++) begin
      if (out_valid) ov_bad = 1;
      tick(); #1;
    end
    chk("no emit after reset", 32'(ov_bad), 32'd0);

    run_frame(2, {32'h3F800000, 32'h3F800000, 32'h0, 32'h0}, 32'h40000000, 0, "post reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ahfp_accum_stream.md
Name: ahfp_accum_stream

Overview:
- Streaming single-precision FP accumulator. Takes a frame of IEEE-754 words over a valid/ready handshake and returns their sum.
- Acts as the operand-issuing and result-collecting end of the pipelined FP adder (ahfp_add_sub_multi, fixed LATENCY cycles). It drives add_a/add_b and consumes add_res.
- Hides adder latency by interleaving LATENCY partial sums. After in_last, it folds the partial sums into one result.

Parameters:
- LATENCY, 7, fixed adder latency in cycles from add_a/add_b to add_res. Must be >= 2.
- SLOT_W, 3, width of slot counter; must satisfy 2**SLOT_W >= LATENCY.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  in_data/in_last valid
- in_ready  output  1  block can accept a word this cycle
- in_data  input  32  IEEE-754 single operand
- in_last  input  1  final word of frame (qualified by in_valid & in_ready)
- out_valid  output  1  frame sum available
- out_ready  input  1  consumer accepts out_data
- out_data  output  32  frame sum
- add_a  output  32  adder operand A
- add_b  output  32  adder operand B
- add_res  input  32  adder result, LATENCY cycles after operands

Behaviour:
- Reset: state=ACC, in_ready=1, out_valid=0, out_data=0, add_a=add_b=0, all partial[0..LATENCY-1]=32'h0, in-flight shift register cleared, slot=0. Reset aborts any frame in any state; nothing is emitted for it.
- Accept: handshake = in_valid & in_ready.
- in_ready = 1 only in ACC.
- States: ACC -> WAIT -> DRAIN -> DONE -> ACC.
- ACC/WAIT slot counter: slot increments every cycle, wraps LATENCY-1 -> 0, whether or not a word is accepted.
- In-flight tracking: fl[LATENCY-1:0] shift register, fl[0] <= accept; each shift moves fl[i] to fl[i+1].
- cur = fl[LATENCY-1] ? add_res : partial[slot]. The slot result always returns on its own slot because the period equals LATENCY.
- On accept: add_a=in_data, add_b=cur; partial[slot] is not written because its value is in flight.
- No accept but fl[LATENCY-1]=1: partial[slot] <= add_res.
- No accept: add_a/add_b = 0. These values are don't-care for the adder; the outputs hold 0.
- ACC -> WAIT: on the cycle that accepts in_last=1.
- WAIT: no accepts. Exit to DRAIN in the cycle after fl becomes all-zero.
- DRAIN: acc <= partial[0]; i runs 1..LATENCY-1.
  - Issue add(acc, partial[i]) once, then wait exactly LATENCY cycles.
  - Capture add_res into acc, then issue the next add on that same cycle.
- After the final capture, enter DONE: out_data=acc, out_valid=1.
- Timing: out_valid rises exactly LATENCY*LATENCY+2 cycles after the in_last accept cycle (LATENCY=7 -> 51).
- DONE: hold out_valid/out_data stable while out_ready=0. On out_valid & out_ready:
  - out_valid <= 0; clear partial[] to 0; slot <= 0.
  - Go to ACC; in_ready=1 next cycle.
- Empty slots contribute +0.0. A 1-word frame returns in_data + 0.0.
- Arithmetic: rounding, NaN and Inf behaviour are inherited from the adder; this block never inspects the data.
- Gaps in in_valid at any position are legal. The result is independent of gap pattern, up to FP reassociation.

Test Plan:
- Frame 1.0,2.0,3.0 (3F800000,40000000,40400000) back-to-back, last on 3rd, out_ready=1 -> out_data=40C00000 (6.0), out_valid rises 51 cycles after last accept, high 1 cycle.
- Single word 5.0 (40A00000) with in_last -> out_data=40A00000; in_ready=0 from cycle after accept until the cycle after the out handshake.
- Ten words of 1.0 with random in_valid gaps (incl. gaps > LATENCY) -> out_data=41200000 (10.0); add_a/add_b checked against a slot-model scoreboard.
- Mixed signs 1.5, -0.5, 2.0 (3FC00000,BF000000,40000000) -> 40400000 (3.0).
- out_ready low 20 cycles in DONE -> out_valid/out_data stable 20 cycles. Next frame 2.0 -> 40000000, with no residue from the prior frame.
- Reset asserted in ACC mid-frame and again in DRAIN -> all outputs at reset values next cycle, no out_valid. Following frame 1.0,1.0 -> 40000000.
